// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    // Decode handshake: an instruction transfers in any cycle where inst_valid
    // and inst_ready are both high; inst_valid never depends on inst_ready.
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_out;
    logic [XLEN-1:0] pc_out;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, pc_out,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, pc_out,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst} pairs between instruction memory and decode.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues 1-cycle-latency word reads and buffers results for decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;
    logic            kill_q;

    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            inst_valid;
    logic            deq;
    logic            issue;
    logic            push;
    logic [2:0]      occupancy;

    always_comb begin
        inst_valid      = !rst && (count != 2'd0);
        deq             = inst_valid && bus.inst_ready;
        // Slots already spoken for once this cycle's dequeue is accounted for.
        occupancy       = {1'b0, count} + {2'b00, inflight_q} - {2'b00, deq};
        issue           = !rst && !bus.redirect_valid && (occupancy < 3'd2);
        push            = !rst && inflight_q && !kill_q && !bus.redirect_valid;
        push_entry.pc   = inflight_pc_q;
        push_entry.inst = bus.imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            kill_q <= bus.redirect_valid ? inflight_q : 1'b0;
            if (bus.redirect_valid) begin
                pc_q       <= word_align(bus.redirect_pc);
                inflight_q <= 1'b0;
            end else if (issue) begin
                pc_q          <= pc_q + 32'd4;
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
            end else begin
                inflight_q <= 1'b0;
            end
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (deq),
        .flush      (bus.redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = rst ? RESET_PC : pc_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_out   = inst_valid ? head.inst : NOP_INST;
    assign bus.pc_out     = inst_valid ? head.pc : '0;

endmodule
